// File: rtl/exec_seq_pkg.sv
// exec_sequencer shared types: state encodings, opcode constants,
// and the regCtrl field packer.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_INCCP  = 3'd2,
    S_DECODE = 3'd3,
    S_FIMM   = 3'd4,
    S_INCCP2 = 3'd5,
    S_EXEC   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_ALU  = 3'd1,
    C_LDI  = 3'd2,
    C_STF  = 3'd3,
    C_HALT = 3'd4,
    C_ILL  = 3'd5
  } opclass_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [5:0] OP_LDI  = 6'b010000;
  localparam logic [7:0] OP_STF  = 8'h60;
  localparam logic [7:0] OP_HALT = 8'hFF;
  localparam logic       ALU_PFX = 1'b1;

  localparam logic [23:0] CTRL_IDLE = 24'h020000;

  localparam logic [1:0] WSEL_CP   = 2'd2;
  localparam logic [2:0] WB_ADDR   = 3'd6;
  localparam logic [1:0] MISC_INC  = 2'b01;
  localparam logic [1:0] BUFF_IMM  = 2'b01;

  typedef struct packed {
    logic [1:0] cy;
    logic [3:0] aluop;
    logic       alum;
    logic [2:0] bsel;
    logic [1:0] wsel;
    logic       wbe;
    logic [2:0] wbsel;
    logic       stfr;
    logic       flen;
    logic [1:0] buff;
    logic [1:0] misc;
  } ctrl_t;

  function automatic ctrl_t idle_fields();
    ctrl_t f;
    f = '0;
    f.flen = 1'b1;
    return f;
  endfunction

  // Each field sits MSB-at-lowest-index inside regCtrl.
  function automatic logic [23:0] pack_ctrl(ctrl_t f);
    return {1'b0, f.misc[0], f.misc[1],
            1'b0, f.buff[0], f.buff[1],
            f.flen, f.stfr,
            f.wbsel[0], f.wbsel[1], f.wbsel[2],
            f.wbe,
            f.wsel[0], f.wsel[1],
            f.bsel[0], f.bsel[1], f.bsel[2],
            f.alum,
            f.aluop[0], f.aluop[1], f.aluop[2], f.aluop[3],
            f.cy[0], f.cy[1]};
  endfunction

endpackage

// File: rtl/exec_seq_opdecode.sv
// Combinational opcode classifier for exec_sequencer.
// Yields class, register index, ALU op/M and the illegal flag.
module exec_opdecode
  import exec_seq_pkg::*;
(
  input  logic [7:0] op,
  output logic [2:0] cls,
  output logic [1:0] rr,
  output logic [3:0] aluop,
  output logic       alum,
  output logic       ill
);

  opclass_t c;

  always_comb begin
    c = C_ILL;
    unique case (1'b1)
      op == OP_HALT:                  c = C_HALT;
      op == OP_NOP:                   c = C_NOP;
      op[7] == ALU_PFX && op != OP_HALT: c = C_ALU;
      op[7:2] == OP_LDI:              c = C_LDI;
      op == OP_STF:                   c = C_STF;
      default:                        c = C_ILL;
    endcase
  end

  assign cls   = c;
  assign rr    = op[1:0];
  assign aluop = op[6:3];
  assign alum  = op[2];
  assign ill   = (c == C_ILL);

endmodule

// File: rtl/exec_sequencer.sv
// Micro-sequencer: fetches opcode/immediate bytes via memReq/memAck
// and issues the executer's registered regCtrl word.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        run,
  input  logic [7:0]  dataIn,
  input  logic        memAck,
  output logic        memReq,
  output logic [23:0] regCtrl,
  output logic        halted,
  output logic        illegal,
  output logic        busErr,
  output logic [2:0]  stateMon
);

  localparam int TLIM = (FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0;

  state_t      state, nxt;
  logic [7:0]  opcode;
  logic [15:0] tcnt;
  logic [2:0]  cls_raw;
  opclass_t    cls;
  logic [1:0]  rr;
  logic [3:0]  aluop;
  logic        alum;
  logic        dec_ill;
  logic        waiting;
  logic        tmo;
  logic        set_ill;
  ctrl_t       f;

  exec_opdecode u_dec (
    .op    (opcode),
    .cls   (cls_raw),
    .rr    (rr),
    .aluop (aluop),
    .alum  (alum),
    .ill   (dec_ill)
  );

  assign cls      = opclass_t'(cls_raw);
  assign waiting  = (state == S_FETCH) || (state == S_FIMM);
  assign tmo      = (FETCH_TIMEOUT > 0) && waiting && !memAck &&
                    (tcnt == 16'(TLIM));
  assign stateMon = state;

  always_comb begin
    nxt     = state;
    set_ill = 1'b0;
    unique case (state)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH: begin
        if (tmo)         nxt = S_HALT;
        else if (memAck) nxt = S_INCCP;
      end
      S_INCCP:  nxt = S_DECODE;
      S_DECODE: begin
        set_ill = dec_ill;
        unique case (cls)
          C_NOP:        nxt = run ? S_FETCH : S_IDLE;
          C_ALU:        nxt = S_EXEC;
          C_LDI, C_STF: nxt = S_FIMM;
          default:      nxt = S_HALT;
        endcase
      end
      S_FIMM: begin
        if (tmo)         nxt = S_HALT;
        else if (memAck) nxt = S_INCCP2;
      end
      S_INCCP2, S_EXEC: nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // The FIMM word is registered on entry and held, so it is
  // present in whichever cycle memAck finally arrives.
  always_comb begin
    f = idle_fields();
    unique case (nxt)
      S_FETCH: f.wsel = WSEL_CP;
      S_INCCP, S_INCCP2: begin
        f.wsel  = WSEL_CP;
        f.misc  = MISC_INC;
        f.wbe   = 1'b1;
        f.wbsel = WB_ADDR;
      end
      S_FIMM: begin
        f.wsel = WSEL_CP;
        f.buff = BUFF_IMM;
        if (cls == C_LDI) begin
          f.wbe   = 1'b1;
          f.wbsel = {1'b0, rr};
        end else begin
          f.stfr = 1'b1;
          f.flen = 1'b0;
        end
      end
      S_EXEC: begin
        f.aluop = aluop;
        f.alum  = alum;
        f.bsel  = {1'b0, rr};
        f.cy    = alum ? 2'b00 : 2'b01;
        f.flen  = 1'b0;
        f.wbe   = 1'b1;
        f.wbsel = {1'b0, rr};
      end
      default: f = idle_fields();
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= S_IDLE;
      opcode  <= 8'h00;
      tcnt    <= '0;
      regCtrl <= CTRL_IDLE;
      memReq  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      busErr  <= 1'b0;
    end else begin
      state   <= nxt;
      regCtrl <= pack_ctrl(f);
      memReq  <= (nxt == S_FETCH) || (nxt == S_FIMM);
      halted  <= (nxt == S_HALT);
      if (set_ill) illegal <= 1'b1;
      if (tmo)     busErr  <= 1'b1;
      if (state == S_FETCH && memAck) opcode <= dataIn;
      tcnt <= (waiting && !memAck) ? tcnt + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: per-cycle expectations are
// queued by the driver and checked by an independent monitor.
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nReset, nres_t, run, memAck, ack_t;
  logic [7:0]  dataIn;

  logic        mq0, h0, il0, be0;
  logic [23:0] rc0;
  logic [2:0]  sm0;
  logic        mq1, h1, il1, be1;
  logic [23:0] rc1;
  logic [2:0]  sm1;

  exec_sequencer #(.FETCH_TIMEOUT(0)) dut (
    .clk(clk), .nReset(nReset), .run(run), .dataIn(dataIn),
    .memAck(memAck), .memReq(mq0), .regCtrl(rc0), .halted(h0),
    .illegal(il0), .busErr(be0), .stateMon(sm0)
  );

  exec_sequencer #(.FETCH_TIMEOUT(4)) dut_to (
    .clk(clk), .nReset(nres_t), .run(run), .dataIn(dataIn),
    .memAck(ack_t), .memReq(mq1), .regCtrl(rc1), .halted(h1),
    .illegal(il1), .busErr(be1), .stateMon(sm1)
  );

  localparam logic [23:0] W_IDLE  = 24'h020000;
  localparam logic [23:0] W_FETCH = 24'h020400;
  localparam logic [23:0] W_INC   = 24'h427400;
  localparam logic [23:0] W_LDI2  = 24'h0A5400;
  localparam logic [23:0] W_STF   = 24'h090400;
  localparam logic [23:0] W_EXB5  = 24'h009258;

  // flags: {memReq, halted, illegal, busErr}
  localparam logic [3:0] F0  = 4'b0000;
  localparam logic [3:0] FM  = 4'b1000;
  localparam logic [3:0] FHI = 4'b0110;
  localparam logic [3:0] FHB = 4'b0101;

  typedef struct {
    bit          inst;
    logic [30:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input bit i, input logic nr, input logic r,
                     input logic a, input logic [7:0] d,
                     input logic [2:0] st, input logic [23:0] w,
                     input logic [3:0] fl, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    if (i) nres_t = nr;
    else   nReset = nr;
    run    = r;
    memAck = a;
    dataIn = d;
    e.inst = i;
    e.v    = {st, w, fl};
    e.nm   = nm;
    q.push_back(e);
  endtask

  exp_t        me;
  logic [30:0] act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me  = q.pop_front();
      act = me.inst ? {sm1, rc1, mq1, h1, il1, be1}
                    : {sm0, rc0, mq0, h0, il0, be0};
      checks++;
      if (act !== me.v) begin
        errors++;
        $display("FAIL %s: got st=%0d ctrl=%06h mq/h/il/be=%04b, want st=%0d ctrl=%06h mq/h/il/be=%04b",
                 me.nm, act[30:28], act[27:4], act[3:0],
                 me.v[30:28], me.v[27:4], me.v[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    nres_t = 1'b0;
    run    = 1'b0;
    memAck = 1'b0;
    ack_t  = 1'b0;
    dataIn = 8'h00;
    repeat (2) @(posedge clk);

    cyc(0, 0, 0, 0, 8'h00, 0, W_IDLE,  F0,  "reset_held");
    cyc(0, 1, 1, 0, 8'h00, 0, W_IDLE,  F0,  "idle_after_reset");
    cyc(0, 1, 1, 1, 8'h00, 1, W_FETCH, FM,  "nop_fetch");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "nop_inccp");
    cyc(0, 1, 1, 0, 8'h00, 3, W_IDLE,  F0,  "nop_decode");
    cyc(0, 1, 1, 1, 8'h42, 1, W_FETCH, FM,  "ldi_fetch");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "ldi_inccp");
    cyc(0, 1, 1, 0, 8'h00, 3, W_IDLE,  F0,  "ldi_decode");
    cyc(0, 1, 1, 1, 8'h5A, 4, W_LDI2,  FM,  "ldi_fimm_ack");
    cyc(0, 1, 1, 0, 8'h00, 5, W_INC,   F0,  "ldi_inccp2");
    cyc(0, 1, 1, 0, 8'h00, 1, W_FETCH, FM,  "alu_fetch_wait");
    cyc(0, 1, 1, 1, 8'hB5, 1, W_FETCH, FM,  "alu_fetch_ack");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "alu_inccp");
    cyc(0, 1, 1, 0, 8'h00, 3, W_IDLE,  F0,  "alu_decode");
    cyc(0, 1, 1, 0, 8'h00, 6, W_EXB5,  F0,  "alu_exec");
    cyc(0, 1, 1, 1, 8'h60, 1, W_FETCH, FM,  "stf_fetch");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "stf_inccp");
    cyc(0, 1, 1, 0, 8'h00, 3, W_IDLE,  F0,  "stf_decode");
    cyc(0, 1, 1, 0, 8'h00, 4, W_STF,   FM,  "stf_fimm_wait");
    cyc(0, 1, 0, 1, 8'hA5, 4, W_STF,   FM,  "stf_fimm_ack");
    cyc(0, 1, 0, 0, 8'h00, 5, W_INC,   F0,  "stf_inccp2");
    cyc(0, 1, 0, 1, 8'h00, 0, W_IDLE,  F0,  "idle_run_low");
    cyc(0, 1, 1, 0, 8'h00, 0, W_IDLE,  F0,  "idle_stays");
    cyc(0, 1, 1, 1, 8'h33, 1, W_FETCH, FM,  "ill_fetch");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "ill_inccp");
    cyc(0, 1, 0, 1, 8'h00, 3, W_IDLE,  F0,  "ill_decode");
    cyc(0, 1, 1, 1, 8'h00, 7, W_IDLE,  FHI, "ill_halt");
    cyc(0, 1, 0, 1, 8'h00, 7, W_IDLE,  FHI, "halt_hold1");
    cyc(0, 1, 1, 0, 8'h00, 7, W_IDLE,  FHI, "halt_hold2");
    cyc(0, 0, 0, 0, 8'h00, 0, W_IDLE,  F0,  "halt_reset");
    cyc(0, 1, 1, 0, 8'h00, 0, W_IDLE,  F0,  "rel_run");
    cyc(0, 1, 1, 1, 8'hB5, 1, W_FETCH, FM,  "rst_fetch");
    cyc(0, 1, 1, 0, 8'h00, 2, W_INC,   F0,  "rst_inccp");
    cyc(0, 1, 1, 0, 8'h00, 3, W_IDLE,  F0,  "rst_decode");
    cyc(0, 0, 0, 0, 8'h00, 0, W_IDLE,  F0,  "rst_in_exec");
    cyc(0, 1, 0, 0, 8'h00, 0, W_IDLE,  F0,  "post_rst_idle1");
    cyc(0, 1, 1, 0, 8'h00, 0, W_IDLE,  F0,  "post_rst_idle2");
    cyc(0, 0, 0, 0, 8'h00, 0, W_IDLE,  F0,  "rst_in_fetch");
    cyc(0, 1, 0, 0, 8'h00, 0, W_IDLE,  F0,  "after_fetch_rst");

    cyc(1, 1, 1, 0, 8'h00, 0, W_IDLE,  F0,  "to_idle");
    for (int k = 0; k < 4; k++)
      cyc(1, 1, 1, 0, 8'h00, 1, W_FETCH, FM, "to_fetch_wait");
    cyc(1, 1, 1, 0, 8'h00, 7, W_IDLE,  FHB, "to_halt");
    cyc(1, 1, 0, 0, 8'h00, 7, W_IDLE,  FHB, "to_halt_hold");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
